// File: rtl/axi_read_streamer_pkg.sv
// Shared types and constants for the AXI burst read streamer.
package axi_read_streamer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } state_e;

  localparam int unsigned BYTES_PER_BEAT = 64;
  localparam int unsigned BEAT_SHIFT     = 6;
  localparam int unsigned PAGE_BYTES     = 4096;

  typedef logic [63:0] beat_cnt_t;

  function automatic beat_cnt_t min_beats(input beat_cnt_t a, input beat_cnt_t b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer carrying data+last; ready_o comes straight from the occupancy register.
module axis_skid_buffer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] data_i,
  input  logic             last_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o,
  output logic             last_o
);

  logic [Width:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]     cnt_q, cnt_d;
  logic           push, pop;

  assign ready_o = (cnt_q != 2'd2);
  assign valid_o = (cnt_q != 2'd0);
  assign push    = valid_i && ready_o;
  assign pop     = valid_o && ready_i;
  assign data_o  = head_q[Width-1:0];
  assign last_o  = head_q[Width];

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    unique case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = {last_i, data_i};
        else               tail_d = {last_i, data_i};
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        // Occupancy unchanged; the head always holds the oldest beat.
        if (cnt_q == 2'd2) begin
          head_d = tail_q;
          tail_d = {last_i, data_i};
        end else begin
          head_d = {last_i, data_i};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/axi_burst_read_streamer.sv
// Fetches a byte range over AXI4 read bursts and returns it as an AXI4-Stream with tlast.
// Optional stat counters are enabled by defining READ_STREAMER_STATS_EN.
module axi_burst_read_streamer
  import axi_read_streamer_pkg::*;
#(
  parameter int unsigned C_DATA_WIDTH      = 512,
  parameter int unsigned C_ADDR_WIDTH      = 64,
  parameter int unsigned C_MAX_BURST_BEATS = 64,
  parameter int unsigned C_MAX_OUTSTANDING = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ctrl_start,
  output logic                    ctrl_done,
  input  logic [63:0]             ctrl_addr_offset,
  input  logic [63:0]             ctrl_xfer_size_in_bytes,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  output logic [C_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  input  logic [C_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic                    m_axi_rlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                    m_axis_tlast
`ifdef READ_STREAMER_STATS_EN
  ,
  output logic [63:0]             stat_beats,
  output logic [31:0]             stat_stall_cycles
`endif
);

  localparam int unsigned OutW = $clog2(C_MAX_OUTSTANDING + 1);

  state_e                  state_q, state_d;
  beat_cnt_t               total_q, total_d;
  beat_cnt_t               ar_rem_q, ar_rem_d;
  beat_cnt_t               r_cnt_q, r_cnt_d;
  logic [C_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [OutW-1:0]         outst_q, outst_d;

  beat_cnt_t               start_beats, page_beats, burst;
  logic [C_ADDR_WIDTH-1:0] start_addr;
  logic                    in_xfer, ar_hs, r_hs, r_last_hs, t_hs, skid_ready, last_in;

  assign start_beats = (ctrl_xfer_size_in_bytes + 64'd63) >> BEAT_SHIFT;
  assign start_addr  = ctrl_addr_offset[C_ADDR_WIDTH-1:0] & ~C_ADDR_WIDTH'(BYTES_PER_BEAT - 1);

  // Beats left before the next 4 KiB boundary; a burst must never cross one.
  assign page_beats = beat_cnt_t'(PAGE_BYTES >> BEAT_SHIFT) - beat_cnt_t'(addr_q[11:BEAT_SHIFT]);
  assign burst      = min_beats(min_beats(ar_rem_q, beat_cnt_t'(C_MAX_BURST_BEATS)), page_beats);

  assign in_xfer       = (state_q == StIssue) || (state_q == StDrain);
  assign m_axi_arvalid = (state_q == StIssue) && (outst_q != OutW'(C_MAX_OUTSTANDING));
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = (state_q == StIssue) ? (burst[7:0] - 8'd1) : 8'd0;
  assign m_axi_rready  = in_xfer && skid_ready;
  assign ctrl_done     = (state_q == StDone);

  assign ar_hs     = m_axi_arvalid && m_axi_arready;
  assign r_hs      = m_axi_rvalid && m_axi_rready;
  assign r_last_hs = r_hs && m_axi_rlast;
  assign t_hs      = m_axis_tvalid && m_axis_tready;
  // tlast is tagged on entry by position in the transfer, independent of rlast.
  assign last_in   = (r_cnt_q == total_q - 64'd1);

  axis_skid_buffer #(
    .Width (C_DATA_WIDTH)
  ) u_skid (
    .clk_i   (clk),
    .rst_i   (reset),
    .valid_i (m_axi_rvalid && in_xfer),
    .ready_o (skid_ready),
    .data_i  (m_axi_rdata),
    .last_i  (last_in),
    .valid_o (m_axis_tvalid),
    .ready_i (m_axis_tready),
    .data_o  (m_axis_tdata),
    .last_o  (m_axis_tlast)
  );

  always_comb begin
    state_d  = state_q;
    total_d  = total_q;
    ar_rem_d = ar_rem_q;
    r_cnt_d  = r_hs ? (r_cnt_q + 64'd1) : r_cnt_q;
    addr_d   = addr_q;
    outst_d  = outst_q;

    unique case ({ar_hs, r_last_hs})
      2'b10:   outst_d = outst_q + OutW'(1);
      2'b01:   outst_d = outst_q - OutW'(1);
      default: ;
    endcase

    unique case (state_q)
      StIdle: begin
        if (ctrl_start) begin
          addr_d   = start_addr;
          total_d  = start_beats;
          ar_rem_d = start_beats;
          r_cnt_d  = '0;
          state_d  = (start_beats == '0) ? StDone : StIssue;
        end
      end
      StIssue: begin
        if (ar_hs) begin
          addr_d   = addr_q + C_ADDR_WIDTH'(burst << BEAT_SHIFT);
          ar_rem_d = ar_rem_q - burst;
          if (ar_rem_q == burst) state_d = StDrain;
        end
      end
      StDrain: begin
        if (t_hs && m_axis_tlast) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      total_q  <= '0;
      ar_rem_q <= '0;
      r_cnt_q  <= '0;
      addr_q   <= '0;
      outst_q  <= '0;
    end else begin
      state_q  <= state_d;
      total_q  <= total_d;
      ar_rem_q <= ar_rem_d;
      r_cnt_q  <= r_cnt_d;
      addr_q   <= addr_d;
      outst_q  <= outst_d;
    end
  end

`ifdef READ_STREAMER_STATS_EN
  logic [63:0] stat_beats_q;
  logic [31:0] stat_stall_q;

  always_ff @(posedge clk) begin
    if (reset || ((state_q == StIdle) && ctrl_start)) begin
      stat_beats_q <= '0;
      stat_stall_q <= '0;
    end else begin
      if (t_hs && (stat_beats_q != '1)) stat_beats_q <= stat_beats_q + 64'd1;
      if (m_axis_tvalid && !m_axis_tready && (stat_stall_q != '1)) begin
        stat_stall_q <= stat_stall_q + 32'd1;
      end
    end
  end

  assign stat_beats        = stat_beats_q;
  assign stat_stall_cycles = stat_stall_q;
`endif

endmodule

// File: tb/tb_axi_burst_read_streamer.sv
// Self-checking bench: AXI read slave model plus stream scoreboard for axi_burst_read_streamer.
module tb_axi_burst_read_streamer;
  import axi_read_streamer_pkg::*;

  localparam int unsigned DW = 512;
  localparam int unsigned AW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, ctrl_start, ctrl_done;
  logic [63:0]   ctrl_addr_offset, ctrl_xfer_size_in_bytes;
  logic          m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready, m_axi_rlast;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [DW-1:0] m_axi_rdata, m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
`ifdef READ_STREAMER_STATS_EN
  logic [63:0]   stat_beats;
  logic [31:0]   stat_stall_cycles;
`endif

  axi_burst_read_streamer dut (
    .clk                     (clk),
    .reset                   (reset),
    .ctrl_start              (ctrl_start),
    .ctrl_done               (ctrl_done),
    .ctrl_addr_offset        (ctrl_addr_offset),
    .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
    .m_axi_arvalid           (m_axi_arvalid),
    .m_axi_arready           (m_axi_arready),
    .m_axi_araddr            (m_axi_araddr),
    .m_axi_arlen             (m_axi_arlen),
    .m_axi_rvalid            (m_axi_rvalid),
    .m_axi_rready            (m_axi_rready),
    .m_axi_rdata             (m_axi_rdata),
    .m_axi_rlast             (m_axi_rlast),
    .m_axis_tvalid           (m_axis_tvalid),
    .m_axis_tready           (m_axis_tready),
    .m_axis_tdata            (m_axis_tdata),
    .m_axis_tlast            (m_axis_tlast)
`ifdef READ_STREAMER_STATS_EN
    ,
    .stat_beats              (stat_beats),
    .stat_stall_cycles       (stat_stall_cycles)
`endif
  );

  typedef struct packed {logic [DW-1:0] data; logic last;} beat_t;
  typedef struct packed {logic [63:0] addr; logic [7:0] len;} ar_t;

  beat_t exp_q[$];
  ar_t   exp_ar_q[$];
  ar_t   pend_q[$];

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0, ar_cnt = 0, beat_cnt = 0, done_cnt = 0, outst = 0;
  int unsigned last_cyc = 0, done_cyc = 0, start_cyc = 0, arv_seen = 0, tv_seen = 0;
  int unsigned r_beat = 0;
  int          r_budget = -1;
  bit          ar_rand = 0, r_rand = 0, t_rand = 0, t_stop = 0;
  bit          r_hs_prev = 0, held_v = 0;
  logic [DW-1:0] held_d;
  logic          held_l;

  function automatic logic [DW-1:0] mem_word(input logic [63:0] a);
    logic [DW-1:0] w;
    logic [31:0]   idx;
    idx = a[37:6];
    for (int i = 0; i < int'(DW / 32); i++) begin
      w[i*32 +: 32] = (idx * 32'h9E37_79B9) ^ (32'(i) << 24) ^ a[63:32];
    end
    return w;
  endfunction

  // AXI slave, stream sink and scoreboard; drives on negedge, samples handshakes 1ns later.
  initial begin
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rdata   = '0;
    m_axi_rlast   = 1'b0;
    m_axis_tready = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (r_hs_prev) m_axi_rvalid = 1'b0;
      m_axi_arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axis_tready = t_stop ? 1'b0 : (t_rand ? 1'($urandom_range(0, 1)) : 1'b1);
      if (!m_axi_rvalid && pend_q.size() > 0 && r_budget != 0 &&
          (!r_rand || $urandom_range(0, 1) == 1)) begin
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = mem_word(pend_q[0].addr + 64'(r_beat) * 64);
        m_axi_rlast  = (r_beat == int'(pend_q[0].len));
        if (r_budget > 0) r_budget--;
      end
      #1;
      if (reset) begin
        pend_q.delete();
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        r_beat       = 0;
        r_hs_prev    = 0;
        held_v       = 0;
        outst        = 0;
        continue;
      end
      if (m_axi_arvalid) arv_seen++;
      if (m_axis_tvalid) tv_seen++;
      if (m_axi_arvalid && m_axi_arready) begin
        checks++;
        if (exp_ar_q.size() == 0) begin
          errors++;
          $display("FAIL ar_unexpected: got addr %0h len %0d expected no burst",
                   m_axi_araddr, m_axi_arlen);
        end else if ({m_axi_araddr, m_axi_arlen} !== {exp_ar_q[0].addr, exp_ar_q[0].len}) begin
          errors++;
          $display("FAIL ar_burst: got addr %0h len %0d expected addr %0h len %0d",
                   m_axi_araddr, m_axi_arlen, exp_ar_q[0].addr, exp_ar_q[0].len);
        end
        if (exp_ar_q.size() > 0) void'(exp_ar_q.pop_front());
        pend_q.push_back('{addr: m_axi_araddr, len: m_axi_arlen});
        ar_cnt++;
        outst++;
        checks++;
        if (outst > 16) begin
          errors++;
          $display("FAIL outstanding_limit: got %0d expected at most 16", outst);
        end
      end
      r_hs_prev = m_axi_rvalid && m_axi_rready;
      if (r_hs_prev) begin
        if (m_axi_rlast) begin
          void'(pend_q.pop_front());
          r_beat = 0;
          outst--;
        end else begin
          r_beat++;
        end
      end
      if (held_v) begin
        checks++;
        if (!m_axis_tvalid || m_axis_tdata !== held_d || m_axis_tlast !== held_l) begin
          errors++;
          $display("FAIL stall_stable: got valid %0b last %0b expected valid 1 last %0b, data held",
                   m_axis_tvalid, m_axis_tlast, held_l);
        end
      end
      held_v = m_axis_tvalid && !m_axis_tready;
      held_d = m_axis_tdata;
      held_l = m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: got beat with last %0b expected none", m_axis_tlast);
        end else begin
          if ({m_axis_tdata, m_axis_tlast} !== {exp_q[0].data, exp_q[0].last}) begin
            errors++;
            $display("FAIL beat %0d: got last %0b data %0h expected last %0b data %0h",
                     beat_cnt + 1, m_axis_tlast, m_axis_tdata, exp_q[0].last, exp_q[0].data);
          end
          void'(exp_q.pop_front());
        end
        beat_cnt++;
        if (m_axis_tlast) last_cyc = cyc;
      end
      if (ctrl_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic start_xfer(input logic [63:0] off, input logic [63:0] size);
    logic [63:0] beats, rem, a, b, page;
    beats = (size + 64'd63) >> 6;
    a     = off & ~64'h3F;
    for (logic [63:0] i = 0; i < beats; i++) begin
      exp_q.push_back('{data: mem_word(a + i * 64), last: (i == beats - 1)});
    end
    rem = beats;
    while (rem > 0) begin
      page = 64'd64 - 64'(a[11:6]);
      b    = (rem < 64) ? rem : 64'd64;
      if (page < b) b = page;
      exp_ar_q.push_back('{addr: a, len: 8'(b - 1)});
      a   = a + b * 64;
      rem = rem - b;
    end
    @(negedge clk);
    ctrl_addr_offset        = off;
    ctrl_xfer_size_in_bytes = size;
    ctrl_start              = 1'b1;
    #2 start_cyc = cyc;
    @(negedge clk);
    ctrl_start = 1'b0;
  endtask

  task automatic clear_counts();
    ar_cnt   = 0;
    beat_cnt = 0;
    arv_seen = 0;
    tv_seen  = 0;
  endtask

  task automatic wait_done(input int unsigned d0, input int budget, output bit timed_out);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    timed_out = (done_cnt == d0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    exp_ar_q.delete();
    r_budget = -1;
    @(negedge clk);
    #2;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if ({m_axi_arvalid, m_axi_rready, m_axis_tvalid, m_axis_tlast, ctrl_done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %05b expected 00000",
               {m_axi_arvalid, m_axi_rready, m_axis_tvalid, m_axis_tlast, ctrl_done});
    end
    checks++;
    if ({m_axi_araddr, m_axi_arlen} !== 72'd0) begin
      errors++;
      $display("FAIL reset_ar: got addr %0h len %0d expected 0 0", m_axi_araddr, m_axi_arlen);
    end
    checks++;
    if (m_axis_tdata !== '0) begin
      errors++;
      $display("FAIL reset_tdata: got %0h expected 0", m_axis_tdata);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    checks++;
    if ({m_axi_arvalid, m_axis_tvalid, ctrl_done} !== 3'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got %03b expected 000",
               {m_axi_arvalid, m_axis_tvalid, ctrl_done});
    end
  endtask

  task automatic run_xfer(input string name, input logic [63:0] off, input logic [63:0] size,
                          input int unsigned n_ar, input int unsigned n_beats);
    int unsigned d0;
    bit to;
    clear_counts();
    d0 = done_cnt;
    start_xfer(off, size);
    wait_done(d0, 5000, to);
    repeat (4) @(negedge clk);
    #2;
    checks++;
    if (to) begin
      errors++;
      $display("FAIL %s_timeout: got no ctrl_done expected ctrl_done", name);
    end
    checks++;
    if (ar_cnt != n_ar || beat_cnt != n_beats) begin
      errors++;
      $display("FAIL %s_counts: got %0d bursts %0d beats expected %0d bursts %0d beats",
               name, ar_cnt, beat_cnt, n_ar, n_beats);
    end
    checks++;
    if (done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL %s_done_pulses: got %0d expected 1", name, done_cnt - d0);
    end
    checks++;
    if (done_cyc != last_cyc + 1) begin
      errors++;
      $display("FAIL %s_done_timing: got cycle %0d expected %0d", name, done_cyc, last_cyc + 1);
    end
    checks++;
    if (exp_q.size() != 0 || exp_ar_q.size() != 0) begin
      errors++;
      $display("FAIL %s_leftover: got %0d beats %0d bursts pending expected 0 0",
               name, exp_q.size(), exp_ar_q.size());
    end
  endtask

  task automatic test_two_pages();
    run_xfer("two_pages", 64'h8000_0000, 64'd8192, 2, 128);
  endtask

  task automatic test_page_cross();
    run_xfer("page_cross", 64'h8000_0FC0, 64'd256, 2, 4);
  endtask

  task automatic test_ceil();
    run_xfer("ceil", 64'h0000_2000, 64'd100, 1, 2);
  endtask

  task automatic test_zero();
    int unsigned d0;
    bit to;
    clear_counts();
    d0 = done_cnt;
    start_xfer(64'h4000, 64'd0);
    wait_done(d0, 20, to);
    repeat (4) @(negedge clk);
    #2;
    checks++;
    if (to || done_cyc != start_cyc + 1) begin
      errors++;
      $display("FAIL zero_done_timing: got cycle %0d expected %0d", done_cyc, start_cyc + 1);
    end
    checks++;
    if (done_cnt != d0 + 1 || arv_seen != 0 || tv_seen != 0) begin
      errors++;
      $display("FAIL zero_activity: got %0d done %0d arvalid %0d tvalid expected 1 0 0",
               done_cnt - d0, arv_seen, tv_seen);
    end
  endtask

  task automatic test_outstanding();
    clear_counts();
    r_budget = 0;
    start_xfer(64'h0, 64'd1048576);
    repeat (100) @(negedge clk);
    #2;
    checks++;
    if (ar_cnt != 16 || m_axi_arvalid !== 1'b0) begin
      errors++;
      $display("FAIL outstanding_cap: got %0d bursts arvalid %0b expected 16 bursts arvalid 0",
               ar_cnt, m_axi_arvalid);
    end
    r_budget = 64;
    repeat (150) @(negedge clk);
    #2;
    checks++;
    if (ar_cnt != 17 || m_axi_arvalid !== 1'b0) begin
      errors++;
      $display("FAIL outstanding_release: got %0d bursts arvalid %0b expected 17 bursts arvalid 0",
               ar_cnt, m_axi_arvalid);
    end
    apply_reset();
    reset = 1'b0;
  endtask

  task automatic test_random();
    ar_rand = 1;
    r_rand  = 1;
    t_rand  = 1;
    run_xfer("random", 64'h1234_0F80, 64'd8192, 3, 128);
`ifdef READ_STREAMER_STATS_EN
    checks++;
    if (stat_beats != 64'd128) begin
      errors++;
      $display("FAIL stat_beats: got %0d expected 128", stat_beats);
    end
`endif
    ar_rand = 0;
    r_rand  = 0;
    t_rand  = 0;
  endtask

  task automatic test_reset_mid_drain();
    int n = 0;
    clear_counts();
    t_stop = 1;
    start_xfer(64'h8000_0000, 64'd8192);
    while (ar_cnt < 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    #2;
    checks++;
    if (ar_cnt != 2 || dut.state_q !== StDrain) begin
      errors++;
      $display("FAIL drain_reached: got %0d bursts state %0d expected 2 bursts state %0d",
               ar_cnt, dut.state_q, StDrain);
    end
    apply_reset();
    checks++;
    if ({m_axi_arvalid, m_axi_rready, m_axis_tvalid, m_axis_tlast, ctrl_done} !== 5'b0 ||
        {m_axi_araddr, m_axi_arlen} !== 72'd0 || m_axis_tdata !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got ctrl %05b addr %0h len %0d expected all 0",
               {m_axi_arvalid, m_axi_rready, m_axis_tvalid, m_axis_tlast, ctrl_done},
               m_axi_araddr, m_axi_arlen);
    end
    checks++;
    if (dut.state_q !== StIdle) begin
      errors++;
      $display("FAIL mid_reset_state: got %0d expected %0d", dut.state_q, StIdle);
    end
    reset  = 1'b0;
    t_stop = 0;
    run_xfer("after_reset", 64'h8000_0FC0, 64'd256, 2, 4);
  endtask

  initial begin
    reset                   = 1'b1;
    ctrl_start              = 1'b0;
    ctrl_addr_offset        = '0;
    ctrl_xfer_size_in_bytes = '0;
    test_reset();
    test_two_pages();
    test_page_cross();
    test_ceil();
    test_zero();
    test_outstanding();
    test_random();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_burst_read_streamer.md
Name: axi_burst_read_streamer

Overview:
Responder side of the ctrl_start/ctrl_done + m_axis read interface that search_and_add_ctrl drives. On ctrl_start it fetches ctrl_xfer_size_in_bytes bytes from device memory at ctrl_addr_offset via an AXI4 read master. It returns the data as a 512-bit AXI4-Stream with tlast on the final beat, then pulses ctrl_done. It sits between the kernel's m_axi port and search_and_add_ctrl.

Parameters:
C_DATA_WIDTH, 512, AXI R / m_axis data width in bits (bytes per beat = 64)
C_ADDR_WIDTH, 64, AXI address width
C_MAX_BURST_BEATS, 64, maximum beats per AR burst (arlen max = 63)
C_MAX_OUTSTANDING, 16, maximum AR bursts issued but not yet completed by rlast

Ports:
clk  in  1  clock; all logic is on its rising edge
reset  in  1  synchronous, active-high reset
ctrl_start  in  1  one-cycle request; sampled only in IDLE
ctrl_done  out  1  one-cycle completion pulse
ctrl_addr_offset  in  64  start byte address; must be 64-byte aligned (bits [5:0] ignored)
ctrl_xfer_size_in_bytes  in  64  transfer length in bytes
m_axi_arvalid  out  1  AR valid
m_axi_arready  in  1  AR ready
m_axi_araddr  out  C_ADDR_WIDTH  burst start address
m_axi_arlen  out  8  beats-1
m_axi_rvalid  in  1  R valid
m_axi_rready  out  1  R ready
m_axi_rdata  in  C_DATA_WIDTH  R data
m_axi_rlast  in  1  last beat of burst
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready
m_axis_tdata  out  C_DATA_WIDTH  stream data
m_axis_tlast  out  1  final beat of whole transfer

Behaviour:
- Reset: arvalid, rready, tvalid, tlast, ctrl_done = 0; araddr, arlen, tdata = 0; all counters 0; skid buffer empty; FSM = IDLE. Reset mid-transfer aborts immediately and discards in-flight data. The memory slave must be reset in the same cycle.
- Constant arsize = 6 and arburst = INCR; these are tied off in the top-level wrapper.
- Total beats = ceil(size/64), computed in 64-bit arithmetic as (size+63)>>6. Latched on ctrl_start together with the aligned address.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: on ctrl_start with beats>0, go to ISSUE. On ctrl_start with beats==0, go to DONE, so ctrl_done pulses on the next cycle. ctrl_start outside IDLE is ignored.
  - ISSUE: burst beats = min(remaining AR beats, C_MAX_BURST_BEATS, beats to next 4 KiB boundary). arvalid is held with stable araddr/arlen until arready. On each handshake: araddr += beats*64, remaining AR beats -= beats. When remaining reaches 0, go to DRAIN.
  - arvalid is deasserted whenever the outstanding count equals C_MAX_OUTSTANDING.
  - DRAIN: wait until every beat has been accepted on m_axis. Go to DONE in the cycle after the handshake with tlast.
  - DONE: ctrl_done=1 for exactly one cycle, then IDLE.
- Outstanding counter: +1 on AR handshake, -1 on R handshake with rlast; simultaneous events leave it unchanged. It never exceeds C_MAX_OUTSTANDING.
- R to m_axis passes through a 2-entry skid buffer, so rready is registered and does not depend combinationally on tready. rready = buffer not full. Beat order is preserved. Full throughput is 1 beat/cycle when tready=1.
- m_axis_tlast is asserted on beat number total_beats, counted from 1 at the stream output. rlast has no effect on tlast.
- Stream latency: an R beat accepted in cycle N appears on m_axis no earlier than N+1.
- tvalid/tdata/tlast are held stable while tvalid&&!tready (AXIS rule).

Optional Feature:
READ_STREAMER_STATS_EN
- Defined: adds output ports stat_beats[63:0] and stat_stall_cycles[31:0].
  - stat_beats counts m_axis handshakes.
  - stat_stall_cycles counts cycles with tvalid&&!tready.
  - Both clear on reset and on an accepted ctrl_start, and saturate at their maximum.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package axi_read_streamer_pkg:
  - state enum typedef (IDLE/ISSUE/DRAIN/DONE)
  - BYTES_PER_BEAT=64, BEAT_SHIFT=6, PAGE_BYTES=4096 constants
  - beat-count typedef (64-bit)
- Sub-module axis_skid_buffer: 2-entry, data+last, registered ready, parameterised on width.

Test Plan:
- offset 0x80000000, size 8192, arready=1, tready=1 → 2 AR bursts (arlen 63, 63) at 0x80000000 and 0x80001000. 128 stream beats with tlast only on beat 128, in order; ctrl_done pulses once, the cycle after the last handshake.
- offset 0x80000FC0, size 256 → AR arlen=0 @0x80000FC0, then arlen=2 @0x80001000; 4 beats with tlast on beat 4.
- size 100 → 2 beats (ceil) with tlast on beat 2. size 0 → no arvalid, no tvalid, ctrl_done exactly 1 cycle after ctrl_start.
- size 1 MiB, arready=1, rvalid held 0 → exactly 16 AR handshakes, then arvalid=0. Releasing 1 burst of rvalid beats → 17th AR issued.
- random 50% tready and random rvalid/arready gaps over 128 beats → data matches the memory model bit-exact, no beat lost or duplicated, tdata stable while stalled.
- reset asserted mid-DRAIN → next cycle all outputs 0, FSM IDLE; a new ctrl_start then completes normally.
